// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: four result slots, round-robin broadcast.
// Optional CDB_STATS_EN adds bcCount/stallCount statistics outputs.
module cdb_arbiter #(
  parameter int DW = 32,
  parameter int LW = 4
) (
  input  logic            clk,
  input  logic            nRST,
  input  logic [3:0]      require,
  input  logic [4*DW-1:0] dataIn,
  input  logic [4*LW-1:0] labelIn,
  output logic [3:0]      accept,
  output logic            BCEN,
  output logic [LW-1:0]   BClabel,
  output logic [DW-1:0]   BCdata
`ifdef CDB_STATS_EN
  ,
  output logic [15:0]     bcCount,
  output logic [15:0]     stallCount
`endif
);

  logic [3:0]    vld;
  logic [LW-1:0] lbl [4];
  logic [DW-1:0] dat [4];
  logic [1:0]    rr;
  logic [3:0]    gnt;
  logic          any;
  logic [1:0]    gidx;
  logic [1:0]    idx;

  // Pick the first valid slot at or above rr, wrapping.
  always_comb begin
    any  = 1'b0;
    gidx = rr;
    idx  = rr;
    for (int k = 0; k < 4; k++) begin
      idx = rr + 2'(k);
      if (!any && vld[idx]) begin
        any  = 1'b1;
        gidx = idx;
      end
    end
    gnt = any ? (4'b0001 << gidx) : 4'b0000;
  end

  // A slot can take a new result if empty or drained this cycle.
  assign accept = nRST ? (require & (~vld | gnt)) : 4'b0000;

  // Slot valid bits; a zero label is taken but never stored.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      vld <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept[i])
          vld[i] <= (labelIn[i*LW +: LW] != '0);
        else if (gnt[i])
          vld[i] <= 1'b0;
      end
    end
  end

  // Slot payload capture on accept.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (accept[i]) begin
        lbl[i] <= labelIn[i*LW +: LW];
        dat[i] <= dataIn[i*DW +: DW];
      end
    end
  end

  // Registered broadcast and round-robin pointer advance.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      BCEN    <= 1'b0;
      BClabel <= '0;
      BCdata  <= '0;
      rr      <= 2'd0;
    end else begin
      BCEN <= any;
      if (any) begin
        BClabel <= lbl[gidx];
        BCdata  <= dat[gidx];
        rr      <= gidx + 2'd1;
      end
    end
  end

`ifdef CDB_STATS_EN
  logic stall;
  assign stall = |(require & ~accept);

  // Broadcast count wraps; stall count saturates.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      bcCount    <= 16'd0;
      stallCount <= 16'd0;
    end else begin
      if (any)
        bcCount <= bcCount + 16'd1;
      if (stall && stallCount != 16'hFFFF)
        stallCount <= stallCount + 16'd1;
    end
  end
`endif

endmodule
